// File: rtl/bus_cache_if.sv
// bus_cache_if: CPU-side and memory-side handshake bundle for bus_cache.
// Ports: CPU request/rw/address/data/flush in, data/ready out; memory request/rw/address/data out, data/ready in.
interface bus_cache_if;
   logic        i_request;
   logic        i_rw;
   logic [31:0] i_address;
   logic [31:0] i_data;
   logic [31:0] o_data;
   logic        o_ready;
   logic        i_flush;
   logic        o_mem_request;
   logic        o_mem_rw;
   logic [31:0] o_mem_address;
   logic [31:0] o_mem_data;
   logic [31:0] i_mem_data;
   logic        i_mem_ready;

   modport slave (
      input  i_request,
      input  i_rw,
      input  i_address,
      input  i_data,
      input  i_flush,
      input  i_mem_data,
      input  i_mem_ready,
      output o_data,
      output o_ready,
      output o_mem_request,
      output o_mem_rw,
      output o_mem_address,
      output o_mem_data
   );

   modport master (
      output i_request,
      output i_rw,
      output i_address,
      output i_data,
      output i_flush,
      output i_mem_data,
      output i_mem_ready,
      input  o_data,
      input  o_ready,
      input  o_mem_request,
      input  o_mem_rw,
      input  o_mem_address,
      input  o_mem_data
   );
endinterface

// File: rtl/bus_cache.sv
// bus_cache: direct-mapped write-through one-word-per-line cache, addr[31]=1 uncached.
// Ports: i_clock, i_reset_n (async active-low), bus (bus_cache_if.slave: CPU side + memory side).
module bus_cache #(
   parameter int LINES_LOG2 = 6
) (
   input logic        i_clock,
   input logic        i_reset_n,
   bus_cache_if.slave bus
);
   localparam int LINES = 1 << LINES_LOG2;
   localparam int TAG_W = 30 - LINES_LOG2;

   typedef enum logic [1:0] {
      IDLE,
      MEM_READ,
      MEM_WRITE,
      RESPOND
   } state_t;

   state_t            state_q;
   logic [LINES-1:0]  valid_q;
   logic [LINES-1:0]  valid_d;
   logic              flush_pend_q;
   logic              flush_pend_d;
   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [31:0]       line_q [LINES];

   logic              ready_q;
   logic [31:0]       data_o_q;
   logic              mem_req_q;
   logic              mem_rw_q;
   logic [31:0]       mem_addr_q;
   logic [31:0]       mem_data_q;

   logic [LINES_LOG2-1:0] req_idx;
   logic [TAG_W-1:0]      req_tag;
   logic [LINES_LOG2-1:0] fill_idx;
   logic [TAG_W-1:0]      fill_tag;
   logic                  hit;
   logic                  flush_now;
   logic                  fill_en;
   logic [31:0]           fill_data;

   assign req_idx  = bus.i_address[LINES_LOG2+1:2];
   assign req_tag  = bus.i_address[31:LINES_LOG2+2];
   // The held memory address identifies the line being filled.
   assign fill_idx = mem_addr_q[LINES_LOG2+1:2];
   assign fill_tag = mem_addr_q[31:LINES_LOG2+2];

   assign hit = valid_q[req_idx]
             && (tag_q[req_idx] == req_tag)
             && !bus.i_address[31];

   assign flush_now = (state_q == IDLE)
                   && (bus.i_flush || flush_pend_q);

   assign fill_en = ((state_q == MEM_READ) || (state_q == MEM_WRITE))
                 && bus.i_mem_ready
                 && !mem_addr_q[31];

   assign fill_data = (state_q == MEM_READ) ? bus.i_mem_data : mem_data_q;

   // A flush seen while busy waits for IDLE so it also kills the in-flight fill.
   always_comb begin
      valid_d      = valid_q;
      flush_pend_d = flush_pend_q;
      if (flush_now) begin
         valid_d      = '0;
         flush_pend_d = 1'b0;
      end else if ((state_q != IDLE) && bus.i_flush) begin
         flush_pend_d = 1'b1;
      end
      if (fill_en) begin
         valid_d[fill_idx] = 1'b1;
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         valid_q      <= '0;
         flush_pend_q <= 1'b0;
      end else begin
         valid_q      <= valid_d;
         flush_pend_q <= flush_pend_d;
      end
   end

   always_ff @(posedge i_clock) begin
      if (fill_en) begin
         tag_q[fill_idx]  <= fill_tag;
         line_q[fill_idx] <= fill_data;
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q    <= IDLE;
         ready_q    <= 1'b0;
         data_o_q   <= '0;
         mem_req_q  <= 1'b0;
         mem_rw_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_data_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               // The cycle our own hit pulse is high, the master's
               // still-raised request belongs to the finished access.
               if (ready_q) begin
                  ready_q <= 1'b0;
               end else if (bus.i_request && !flush_now) begin
                  if (bus.i_rw) begin
                     mem_addr_q <= bus.i_address;
                     mem_data_q <= bus.i_data;
                     mem_rw_q   <= 1'b1;
                     mem_req_q  <= 1'b1;
                     state_q    <= MEM_WRITE;
                  end else if (hit) begin
                     data_o_q <= line_q[req_idx];
                     ready_q  <= 1'b1;
                  end else begin
                     mem_addr_q <= bus.i_address;
                     mem_rw_q   <= 1'b0;
                     mem_req_q  <= 1'b1;
                     state_q    <= MEM_READ;
                  end
               end
            end
            MEM_READ: begin
               if (bus.i_mem_ready) begin
                  mem_req_q <= 1'b0;
                  data_o_q  <= bus.i_mem_data;
                  ready_q   <= 1'b1;
                  state_q   <= RESPOND;
               end
            end
            MEM_WRITE: begin
               if (bus.i_mem_ready) begin
                  mem_req_q <= 1'b0;
                  ready_q   <= 1'b1;
                  state_q   <= RESPOND;
               end
            end
            RESPOND: begin
               ready_q <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.o_data        = data_o_q;
   assign bus.o_ready       = ready_q;
   assign bus.o_mem_request = mem_req_q;
   assign bus.o_mem_rw      = mem_rw_q;
   assign bus.o_mem_address = mem_addr_q;
   assign bus.o_mem_data    = mem_data_q;
endmodule

// File: tb/tb_bus_cache.sv
// tb_bus_cache: randomized and directed checks of bus_cache against a line-array model.
// Memory is an associative array behind a responder with programmable wait states.
module tb_bus_cache;
   logic clk = 1'b0;
   logic rst_n = 1'b0;

   bus_cache_if bif ();

   bus_cache #(.LINES_LOG2(6)) dut (
      .i_clock   (clk),
      .i_reset_n (rst_n),
      .bus       (bif)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [logic [29:0]];
   int          wait_cfg = 0;
   int          wcnt = 0;
   bit          busy = 0;
   int          mem_cnt = 0;
   logic [31:0] log_addr = '0;
   logic [31:0] log_wd = '0;
   logic        log_rw = 1'b0;

   bit          mv [64];
   logic [23:0] mt [64];
   logic [31:0] md [64];

   int          last_lat = 0;
   int          last_went = 0;

   bit          prev_rdy = 0;
   bit          prev_mreq = 0;
   logic [31:0] prev_ma = '0;
   logic [31:0] prev_md = '0;
   logic        prev_mrw = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a[31:2])) return mem[a[31:2]];
      return {a[31:2], 2'b00} ^ 32'h5A5A_A5A5;
   endfunction

   function automatic void mclear();
      for (int i = 0; i < 64; i++) mv[i] = 1'b0;
   endfunction

   // Memory responder: raises ready for one cycle after wait_cfg waits.
   always @(negedge clk) begin
      if (!rst_n) begin
         bif.i_mem_ready = 1'b0;
         bif.i_mem_data  = '0;
         busy = 1'b0;
      end else if (bif.i_mem_ready) begin
         bif.i_mem_ready = 1'b0;
         busy = 1'b0;
      end else if (bif.o_mem_request) begin
         if (!busy) begin
            busy = 1'b1;
            wcnt = wait_cfg;
         end
         if (wcnt == 0) begin
            bif.i_mem_ready = 1'b1;
            log_addr = bif.o_mem_address;
            log_rw   = bif.o_mem_rw;
            log_wd   = bif.o_mem_data;
            mem_cnt++;
            if (bif.o_mem_rw) mem[bif.o_mem_address[31:2]] = bif.o_mem_data;
            else bif.i_mem_data = mem_rd(bif.o_mem_address);
         end else begin
            wcnt--;
         end
      end
   end

   // Cycle monitor: handshake rules that hold on every cycle.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_rdy  = 1'b0;
         prev_mreq = 1'b0;
      end else begin
         if (bif.o_ready) begin
            chk("ready_with_req", {31'b0, bif.i_request}, 32'd1);
            chk("ready_pulse", {31'b0, prev_rdy}, 32'd0);
         end
         if (bif.o_mem_request && prev_mreq) begin
            chk("mem_stable",
                {31'b0, (bif.o_mem_address != prev_ma) ||
                        (bif.o_mem_data != prev_md) ||
                        (bif.o_mem_rw != prev_mrw)}, 32'd0);
         end
         prev_rdy  = bif.o_ready;
         prev_mreq = bif.o_mem_request;
         prev_ma   = bif.o_mem_address;
         prev_md   = bif.o_mem_data;
         prev_mrw  = bif.o_mem_rw;
      end
   end

   task automatic access(input logic rw, input logic [31:0] a,
                         input logic [31:0] wd, input bit fl_with,
                         input bit fl_mid, output logic [31:0] rd);
      int          mc0;
      int          lat;
      int          idx;
      bit          exp_hit;
      bit          done;
      bit          fl_on;
      bit          mid_done;
      logic [31:0] exp_d;
      logic [23:0] tg;
      idx = int'(a[7:2]);
      tg  = a[31:8];
      if (fl_with) mclear();
      exp_hit = !rw && !a[31] && mv[idx] && (mt[idx] == tg);
      exp_d   = exp_hit ? md[idx] : mem_rd(a);
      mc0     = mem_cnt;
      @(negedge clk);
      bif.i_request = 1'b1;
      bif.i_rw      = rw;
      bif.i_address = a;
      bif.i_data    = wd;
      bif.i_flush   = fl_with;
      lat = 0;
      done = 0;
      fl_on = fl_with;
      mid_done = 0;
      while (!done && lat < 100) begin
         @(negedge clk);
         lat++;
         if (fl_on) begin
            bif.i_flush = 1'b0;
            fl_on = 0;
         end
         if (bif.o_ready) begin
            done = 1;
         end else if (fl_mid && !mid_done && bif.o_mem_request) begin
            bif.i_flush = 1'b1;
            fl_on = 1;
            mid_done = 1;
         end
      end
      bif.i_flush = 1'b0;
      rd = bif.o_data;
      chk("ready_seen", {31'b0, done}, 32'd1);
      if (!rw) chk("rdata", rd, exp_d);
      chk("mem_txn", mem_cnt - mc0, exp_hit ? 32'd0 : 32'd1);
      if (exp_hit) begin
         chk("hit_lat", lat, 32'd1);
      end else begin
         chk("mem_addr", log_addr, a);
         chk("mem_rw", {31'b0, log_rw}, {31'b0, rw});
         if (rw) chk("mem_wdata", log_wd, wd);
      end
      if (!a[31] && !exp_hit) begin
         mv[idx] = 1'b1;
         mt[idx] = tg;
         md[idx] = rw ? wd : exp_d;
      end
      if (mid_done) mclear();
      last_lat  = lat;
      last_went = mem_cnt - mc0;
      @(posedge clk);
      #1;
      bif.i_request = 1'b0;
   endtask

   task automatic flush_pulse();
      @(negedge clk);
      bif.i_flush = 1'b1;
      @(negedge clk);
      bif.i_flush = 1'b0;
      mclear();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic [31:0] a;
      logic [31:0] wd;
      logic        rw;
      bit          fw;
      bit          fm;
      int          n;
      int          pool [4];
      pool = '{0, 1, 5, 63};
      bif.i_request = 1'b0;
      bif.i_rw      = 1'b0;
      bif.i_address = '0;
      bif.i_data    = '0;
      bif.i_flush   = 1'b0;
      mclear();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'b0, bif.o_ready}, 32'd0);
      chk("rst_mreq", {31'b0, bif.o_mem_request}, 32'd0);
      chk("rst_mrw", {31'b0, bif.o_mem_rw}, 32'd0);
      chk("rst_data", bif.o_data, 32'd0);
      chk("rst_maddr", bif.o_mem_address, 32'd0);
      chk("rst_mdata", bif.o_mem_data, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Cold read then hit
      wait_cfg = 3;
      mem[30'h40] = 32'hDEADBEEF;
      access(1'b0, 32'h100, 32'h0, 0, 0, rd);
      chk("cold_rd", rd, 32'hDEADBEEF);
      chk("cold_went", last_went, 32'd1);
      access(1'b0, 32'h100, 32'h0, 0, 0, rd);
      chk("rehit_rd", rd, 32'hDEADBEEF);
      chk("rehit_lat", last_lat, 32'd1);
      chk("rehit_nomem", last_went, 32'd0);

      // Write-through then hit
      access(1'b1, 32'h100, 32'h12345678, 0, 0, rd);
      chk("wr_addr", log_addr, 32'h100);
      chk("wr_data", log_wd, 32'h12345678);
      access(1'b0, 32'h100, 32'h0, 0, 0, rd);
      chk("wr_hit_rd", rd, 32'h12345678);
      chk("wr_hit_nomem", last_went, 32'd0);

      // Aliasing on index 0
      flush_pulse();
      access(1'b0, 32'h100, 32'h0, 0, 0, rd);
      chk("alias_a_miss", last_went, 32'd1);
      access(1'b0, 32'h200, 32'h0, 0, 0, rd);
      chk("alias_b_miss", last_went, 32'd1);
      access(1'b0, 32'h100, 32'h0, 0, 0, rd);
      chk("alias_refetch", last_went, 32'd1);
      chk("alias_rd", rd, 32'h12345678);

      // Uncached peripheral reads
      mem[30'h2000_0004] = 32'h1;
      access(1'b0, 32'h8000_0010, 32'h0, 0, 0, rd);
      chk("unc_rd1", rd, 32'h1);
      mem[30'h2000_0004] = 32'h2;
      access(1'b0, 32'h8000_0010, 32'h0, 0, 0, rd);
      chk("unc_rd2", rd, 32'h2);
      chk("unc_went2", last_went, 32'd1);

      // Flush in IDLE, flush with request, flush while pending
      access(1'b0, 32'h40, 32'h0, 0, 0, rd);
      access(1'b0, 32'h40, 32'h0, 0, 0, rd);
      chk("fl_prehit", last_went, 32'd0);
      flush_pulse();
      access(1'b0, 32'h40, 32'h0, 0, 0, rd);
      chk("fl_miss", last_went, 32'd1);
      access(1'b0, 32'h40, 32'h0, 1, 0, rd);
      chk("fl_with_req_miss", last_went, 32'd1);
      wait_cfg = 2;
      access(1'b0, 32'h44, 32'h0, 0, 1, rd);
      access(1'b0, 32'h44, 32'h0, 0, 0, rd);
      chk("fl_mid_miss", last_went, 32'd1);

      // Reset during MEM_READ
      wait_cfg = 1;
      access(1'b0, 32'h300, 32'h0, 0, 0, rd);
      wait_cfg = 50;
      @(negedge clk);
      bif.i_request = 1'b1;
      bif.i_rw      = 1'b0;
      bif.i_address = 32'h344;
      n = 0;
      while (!bif.o_mem_request && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("rst_mreq_seen", {31'b0, bif.o_mem_request}, 32'd1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_mreq", {31'b0, bif.o_mem_request}, 32'd0);
      chk("rst_mid_ready", {31'b0, bif.o_ready}, 32'd0);
      bif.i_request = 1'b0;
      mclear();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      wait_cfg = 1;
      access(1'b0, 32'h344, 32'h0, 0, 0, rd);
      chk("rst_same_miss", last_went, 32'd1);
      access(1'b0, 32'h300, 32'h0, 0, 0, rd);
      chk("rst_old_miss", last_went, 32'd1);

      // Randomized traffic over colliding indexes
      for (int k = 0; k < 400; k++) begin
         wait_cfg = $urandom_range(0, 3);
         if ($urandom_range(0, 7) == 0)
            a = 32'h8000_0000 | ($urandom & 32'hFF);
         else
            a = ($urandom_range(0, 2) << 8) |
                (pool[$urandom_range(0, 3)] << 2) |
                $urandom_range(0, 3);
         rw = ($urandom_range(0, 2) == 0);
         wd = $urandom;
         fw = ($urandom_range(0, 19) == 0);
         fm = ($urandom_range(0, 9) == 0);
         access(rw, a, wd, fw, fm, rd);
      end

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/bus_cache.md
Name: bus_cache

Overview:
- Direct-mapped, write-through, one-word-per-line cache between the CPU bus master port and the system memory bus.
- Uses the same request/ready handshake on both sides, so it drops in transparently.
- Read hits complete in 1 cycle.
- Misses, writes and uncached accesses pass through to memory.
- The uncached region is address[31]=1 (peripherals).

Parameters:
- LINES_LOG2, 6, log2 of line count (64 lines); tag = address[31:LINES_LOG2+2], index = address[LINES_LOG2+1:2].

Ports:
- i_clock  in  1  clock; all state updates on the rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_request  in  1  CPU request; held high until o_ready is seen.
- i_rw  in  1  0 = read, 1 = write.
- i_address  in  32  CPU byte address; bits [1:0] are ignored for lookup and passed through to memory.
- i_data  in  32  CPU write data.
- o_data  out  32  read data returned to the CPU.
- o_ready  out  1  one-cycle completion pulse to the CPU.
- i_flush  in  1  invalidate all lines.
- o_mem_request  out  1  memory request.
- o_mem_rw  out  1  memory read/write.
- o_mem_address  out  32  memory address.
- o_mem_data  out  32  memory write data.
- i_mem_data  in  32  memory read data.
- i_mem_ready  in  1  memory ready.

Behaviour:
- Reset (async, i_reset_n=0):
  - All valid bits cleared; state=IDLE.
  - o_ready=0, o_mem_request=0, o_mem_rw=0; o_data, o_mem_address, o_mem_data = 0.
  - Reset mid-transaction aborts it; no line is updated.
- Storage: per line, valid bit, tag, 32-bit data. Registers or inferred RAM, but lookup must be readable in the IDLE cycle.
- States: IDLE, MEM_READ, MEM_WRITE, RESPOND.
- IDLE, with i_request=1 (o_ready=0):
  - Read, cacheable, hit (valid && tag match): o_data <= line data, o_ready <= 1 next edge, stay IDLE. Latency 1 cycle.
  - Read, miss or uncached: o_mem_address <= i_address, o_mem_rw <= 0, o_mem_request <= 1 → MEM_READ.
  - Write (any region): o_mem_address <= i_address, o_mem_data <= i_data, o_mem_rw <= 1, o_mem_request <= 1 → MEM_WRITE.
- MEM_READ, on i_mem_ready=1:
  - o_mem_request <= 0, o_data <= i_mem_data, o_ready <= 1.
  - If cacheable: fill line (valid=1, tag, data).
  - → RESPOND.
- MEM_WRITE, on i_mem_ready=1:
  - o_mem_request <= 0, o_ready <= 1.
  - If cacheable: line <= {valid=1, tag, i_data} (write-allocate; all writes are full-word).
  - → RESPOND.
- RESPOND: o_ready <= 0 → IDLE. The master drops i_request on the edge where it sees o_ready; the cache ignores i_request in RESPOND.
- o_ready:
  - Always a single-cycle pulse.
  - Never asserted while i_request=0.
  - In IDLE the cache does not accept a request during the cycle its own hit o_ready is high; that cycle's i_request is ignored.
- Memory side: o_mem_request held high with stable address/data/rw until i_mem_ready is sampled high, then deasserted on that edge. Wait states are unbounded.
- Uncached accesses (address[31]=1) never read or modify lines.
- Flush:
  - i_flush=1 in IDLE clears all valid bits on that edge.
  - If a request arrives in the same cycle: the flush takes priority and the request is serviced from the next cycle, as a miss.
  - i_flush during MEM_READ/MEM_WRITE/RESPOND is latched (flush_pending) and applied on the first IDLE cycle. The in-flight fill is lost to the flush.
- Aliasing: two addresses with the same index and different tag evict each other; no stale data is ever returned.

Test Plan:
- Cold read 0x0000_0100 with mem returning 0xDEADBEEF after 3 wait cycles:
  - one memory read is issued;
  - o_ready pulses once with o_data=0xDEADBEEF;
  - a repeat read hits with o_ready 1 cycle after request and no o_mem_request.
- Write 0x0000_0100 = 0x12345678 then read 0x0000_0100:
  - memory sees the write with identical address/data;
  - the read hits and returns 0x12345678.
- Read 0x0000_0100, then read alias 0x0000_0200 (LINES_LOG2=6):
  - both miss;
  - a re-read of 0x0000_0100 misses again and refetches.
- Uncached read 0x8000_0010 twice, mem returning 0x1 then 0x2:
  - both go to memory;
  - returns 0x1, then 0x2.
- Fill 0x0000_0040, assert i_flush for 1 cycle, re-read: miss, memory read issued. Flush asserted during a pending MEM_READ takes effect afterwards, so the next read of that line also misses.
- Assert i_reset_n=0 during MEM_READ:
  - o_mem_request and o_ready go 0 immediately;
  - after release, a read of the same address misses.
